// File: rtl/ila_uart_pkg.sv
// Shared definitions for the ILA host UART: receiver state encoding,
// frame width and the default bit period (100 MHz clock at 115200 baud).
package ila_uart_pkg;

  localparam int UART_DATA_WIDTH      = 8;
  localparam int UART_CLOCKS_PER_BAUD = 868;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_t;

  // Clock count from the start edge to the middle of the start bit.
  function automatic int half_baud(input int clocks_per_baud);
    return clocks_per_baud / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level. Kept separate so
// ILA probe inputs can reuse the same cell.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Shift the asynchronous input through two flops; both preset to the idle level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/ila_uart_rx.sv
// UART 8N1 receiver feeding the ILA command decoder. Bytes are offered on a
// valid/ready holding register; bad stop bits and bytes that arrive while the
// holding register is still full are reported as single-cycle pulses.
module ila_uart_rx
  import ila_uart_pkg::*;
#(
  parameter int CLOCKS_PER_BAUD = UART_CLOCKS_PER_BAUD,
  parameter int DATA_WIDTH      = UART_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxd,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  frame_err_o,
  output logic                  overrun_o
);

  localparam int CNT_W = $clog2(CLOCKS_PER_BAUD);
  localparam int BIT_W = $clog2(DATA_WIDTH);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLOCKS_PER_BAUD - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(half_baud(CLOCKS_PER_BAUD) - 1);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  // Reject parameter values the counters cannot represent correctly.
  if (CLOCKS_PER_BAUD < 4) begin : g_bad_baud
    $error("ila_uart_rx: CLOCKS_PER_BAUD must be at least 4");
  end
  if (DATA_WIDTH != 8) begin : g_bad_width
    $error("ila_uart_rx: only 8-bit frames are supported");
  end

  rx_state_t             r_state;
  logic [CNT_W-1:0]      r_baud_cnt;
  logic [BIT_W-1:0]      r_bit_idx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_frame_err;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_overrun;

  logic w_rxd_s;
  logic w_mid_bit;
  logic w_deliver;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (rxd),
    .o_q (w_rxd_s)
  );

  assign w_mid_bit = (r_baud_cnt == BAUD_LAST);
  // A good stop bit hands the assembled byte to the holding register.
  assign w_deliver = (r_state == RX_STOP) && w_mid_bit && w_rxd_s;

  // Frame sequencer: start-bit qualification, mid-bit timing, stop-bit check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RX_IDLE;
      r_baud_cnt  <= '0;
      r_bit_idx   <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (!w_rxd_s) begin
            r_state    <= RX_START;
            r_baud_cnt <= '0;
          end
        end
        RX_START: begin
          if (r_baud_cnt == HALF_LAST) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            // A line that is high again at mid start bit was only a glitch.
            r_state    <= w_rxd_s ? RX_IDLE : RX_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + CNT_ONE;
          end
        end
        RX_DATA: begin
          if (w_mid_bit) begin
            r_baud_cnt <= '0;
            if (r_bit_idx == BIT_LAST) begin
              r_state <= RX_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + BIT_ONE;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + CNT_ONE;
          end
        end
        RX_STOP: begin
          if (w_mid_bit) begin
            r_baud_cnt <= '0;
            if (w_rxd_s) begin
              r_state <= RX_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= RX_WAIT_IDLE;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + CNT_ONE;
          end
        end
        RX_WAIT_IDLE: begin
          // Hold off re-arming until the line has returned high (break).
          if (w_rxd_s) begin
            r_state <= RX_IDLE;
          end
        end
        default: begin
          r_state <= RX_IDLE;
        end
      endcase
    end
  end

  // Data shift register, LSB first; contents only matter once a frame completes.
  always_ff @(posedge clk) begin
    if ((r_state == RX_DATA) && w_mid_bit) begin
      r_shift <= {w_rxd_s, r_shift[DATA_WIDTH-1:1]};
    end
  end

  // Single-entry holding register toward the command decoder, with overrun detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_deliver) begin
        if (!r_valid || ready_i) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_o      = r_data;
  assign valid_o     = r_valid;
  assign frame_err_o = r_frame_err;
  assign overrun_o   = r_overrun;

endmodule
